synth_param_ctrl: RTL
=====================

Name: synth_param_ctrl

Overview:
- Owns the synth's user-adjustable parameter bank: octave, amplitude, attack, decay, sustain, release.
- Turns the level-type PS2 +/- request lines into stepped, saturating register updates, with press-and-hold auto-repeat.
- Sits between the ps2 keyboard decoder and ALUcontroller. Its outputs drive the ALUcontroller parameter inputs, the HEX decoders and the VGA display.
- Replaces the free-running one-second octave strobe and the unbounded per-cycle ADSR arithmetic.

Parameters:
- HOLD_CYCLES, 25000000: cycles a request must stay held after the first step before auto-repeat starts (0.5 s at 50 MHz).
- REPEAT_CYCLES, 5000000: cycles between auto-repeat steps (0.1 s).
- STEP, 8388608: ADSR/amplitude increment (1<<23, giving 128 steps over the full range).
- PARAM_MAX, 1073741824: upper bound for all 31-bit parameters (1<<30).
- OCT_MAX, 7: upper bound for octave. The lower bound is 0.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-low
- octave_plus_plus  in  1  level request: raise octave
- octave_minus_minus  in  1  level request: lower octave
- ADSR_selector  in  3  target select: 0 amplitude, 1 attack, 2 decay, 3 sustain, 4 release, 5-7 none
- ADSR_plus_plus  in  1  level request: raise selected parameter
- ADSR_minus_minus  in  1  level request: lower selected parameter
- octave  out  3  current octave
- amplitude  out  31
- attack  out  31
- decay  out  31
- sustain  out  31
- rel  out  31  release
- param_changed  out  1  one-cycle pulse whenever any output value changes

Behaviour:
- Reset is synchronous, active-low, on clk. At the next edge with reset low:
  - octave=4, amplitude=attack=sustain=rel=PARAM_MAX, decay=0
  - both engines return to IDLE, counters=0, param_changed=0
  - reset overrides any in-progress hold or repeat.
- Two independent repeat engines run concurrently:
  - OCT engine: driven by the octave +/- inputs.
  - ADSR engine: driven by the ADSR +/- inputs and ADSR_selector.
- Request decode per engine:
  - up = plus & ~minus; dn = minus & ~plus.
  - A request is active when up or dn is set.
  - For the ADSR engine the selector must also be 0-4.
  - plus and minus asserted together means no request.
- Engine FSM states are IDLE, HOLD and REPEAT; each engine has one cycle counter.
  - IDLE, request active: apply one step, counter<=0, latch direction (and, for ADSR, selector), go to HOLD.
  - HOLD: counter increments each cycle. When counter==HOLD_CYCLES-1: apply one step, counter<=0, go to REPEAT.
  - REPEAT: counter increments each cycle. When counter==REPEAT_CYCLES-1: apply one step, counter<=0.
  - HOLD/REPEAT exit: on any cycle where the request is inactive, the direction differs from the latched one, or (ADSR) the selector differs from the latched one, go to IDLE with no step that cycle. Re-entry needs a new IDLE detection on a later cycle.
- Latency: a step applied at edge N is visible on the outputs after edge N, i.e. one cycle after the request is first sampled.
- Arithmetic is done in 32-bit intermediate width with saturation, never wrap:
  - up: if value > PARAM_MAX-STEP then PARAM_MAX, else value+STEP.
  - dn: if value < STEP then 0, else value-STEP.
  - octave: up saturates at OCT_MAX, dn saturates at 0.
- A step only modifies the register addressed by the latched selector. The other registers hold.
- param_changed is registered. It is 1 for exactly the cycle after an edge at which any output register took a different value. It is 0 for saturated steps where the value is unchanged. If both engines step on the same edge, one pulse is produced.
- Counters are wide enough for max(HOLD_CYCLES, REPEAT_CYCLES) (25 bits at defaults).

Test Plan (bench overrides HOLD_CYCLES=10, REPEAT_CYCLES=4; STEP and PARAM_MAX at defaults):
- Reset: hold reset low 2 cycles -> octave=4, amplitude=attack=sustain=rel=1073741824, decay=0, param_changed=0.
- Single tap: selector=2, ADSR_plus_plus high for 1 cycle -> decay=8388608 after that edge; param_changed high for 1 cycle; engine back in IDLE.
- Auto-repeat: selector=2, ADSR_plus_plus held 30 edges from decay=0 -> steps at edges 0, 10, 14, 18, 22, 26; final decay=50331648; 6 param_changed pulses.
- Saturation: selector=0, ADSR_plus_plus tap with amplitude=PARAM_MAX -> amplitude unchanged, no pulse. octave_plus_plus taps from 4 -> 5, 6, 7, 7; only 3 pulses. ADSR_minus_minus on decay=0 -> stays 0.
- Conflicts: ADSR plus and minus asserted together for 20 cycles -> no change. Selector switched 2->3 mid-HOLD -> engine drops to IDLE, no further decay steps, sustain steps once on the next cycle if the request is still held.
- Reset mid-REPEAT: assert reset during an octave hold at octave=6 -> octave=4 next edge, engine in IDLE. After reset releases with octave_plus_plus still high -> one step to 5 on the next edge, then HOLD timing restarts.

Source files
------------

// File: rtl/synth_param_ctrl.sv
// synth_param_ctrl: user parameter bank (octave, amplitude, ADSR) with
// saturating stepped updates and press-and-hold auto-repeat on the +/- lines.
module synth_param_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter int unsigned STEP          = 8388608,
  parameter int unsigned PARAM_MAX     = 1073741824,
  parameter int unsigned OCT_MAX       = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        octave_plus_plus,
  input  logic        octave_minus_minus,
  input  logic [2:0]  ADSR_selector,
  input  logic        ADSR_plus_plus,
  input  logic        ADSR_minus_minus,
  output logic [2:0]  octave,
  output logic [30:0] amplitude,
  output logic [30:0] attack,
  output logic [30:0] decay,
  output logic [30:0] sustain,
  output logic [30:0] rel,
  output logic        param_changed
);

  localparam int unsigned PW      = 31;
  localparam int unsigned OW      = 3;
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [31:0]      STEP_W      = 32'(STEP);
  localparam logic [31:0]      MAX_W       = 32'(PARAM_MAX);
  localparam logic [31:0]      UP_LIM      = 32'(PARAM_MAX - STEP);
  localparam logic [OW-1:0]    OCT_TOP     = OW'(OCT_MAX);
  localparam logic [OW-1:0]    OCT_RESET   = 3'd4;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} eng_state_e;

  eng_state_e       oct_state_q, oct_state_d, adsr_state_q, adsr_state_d;
  logic [CNT_W-1:0] oct_cnt_q, oct_cnt_d, adsr_cnt_q, adsr_cnt_d;
  logic             oct_dir_q, oct_dir_d, adsr_dir_q, adsr_dir_d;
  logic [2:0]       adsr_sel_q, adsr_sel_d;
  logic [OW-1:0]    octave_q, octave_d;
  logic [PW-1:0]    amp_q, amp_d, att_q, att_d, dec_q, dec_d, sus_q, sus_d, rel_q, rel_d;
  logic             param_changed_q, param_changed_d;

  logic oct_up, oct_dn, oct_req, oct_keep, oct_step;
  logic adsr_up, adsr_dn, adsr_req, adsr_keep, adsr_step;
  logic       step_dir;
  logic [2:0] step_sel;

  // Saturating 31-bit step computed in 32-bit width
  function automatic logic [PW-1:0] sat_step(input logic [PW-1:0] v, input logic up);
    logic [31:0] w;
    w = {1'b0, v};
    if (up) return (w > UP_LIM) ? PW'(MAX_W) : PW'(w + STEP_W);
    else    return (w < STEP_W) ? '0 : PW'(w - STEP_W);
  endfunction

  // Request decode; a run continues only while direction and target are unchanged
  always_comb begin
    oct_up    = octave_plus_plus & ~octave_minus_minus;
    oct_dn    = octave_minus_minus & ~octave_plus_plus;
    oct_req   = oct_up | oct_dn;
    oct_keep  = oct_req && (oct_up == oct_dir_q);
    adsr_up   = ADSR_plus_plus & ~ADSR_minus_minus;
    adsr_dn   = ADSR_minus_minus & ~ADSR_plus_plus;
    adsr_req  = (adsr_up | adsr_dn) && (ADSR_selector <= 3'd4);
    adsr_keep = adsr_req && (adsr_up == adsr_dir_q) && (ADSR_selector == adsr_sel_q);
  end

  // Engine state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      oct_state_q  <= S_IDLE;
      adsr_state_q <= S_IDLE;
    end else begin
      oct_state_q  <= oct_state_d;
      adsr_state_q <= adsr_state_d;
    end
  end

  // Engine next-state logic
  always_comb begin
    oct_state_d  = oct_state_q;
    adsr_state_d = adsr_state_q;
    case (oct_state_q)
      S_IDLE:   if (oct_req) oct_state_d = S_HOLD;
      S_HOLD:   if (!oct_keep) oct_state_d = S_IDLE;
                else if (oct_cnt_q == HOLD_LAST) oct_state_d = S_REPEAT;
      S_REPEAT: if (!oct_keep) oct_state_d = S_IDLE;
      default:  oct_state_d = S_IDLE;
    endcase
    case (adsr_state_q)
      S_IDLE:   if (adsr_req) adsr_state_d = S_HOLD;
      S_HOLD:   if (!adsr_keep) adsr_state_d = S_IDLE;
                else if (adsr_cnt_q == HOLD_LAST) adsr_state_d = S_REPEAT;
      S_REPEAT: if (!adsr_keep) adsr_state_d = S_IDLE;
      default:  adsr_state_d = S_IDLE;
    endcase
  end

  // Engine outputs: counters, latched direction/target and step strobes
  always_comb begin
    oct_cnt_d  = oct_cnt_q;
    oct_dir_d  = oct_dir_q;
    oct_step   = 1'b0;
    adsr_cnt_d = adsr_cnt_q;
    adsr_dir_d = adsr_dir_q;
    adsr_sel_d = adsr_sel_q;
    adsr_step  = 1'b0;
    case (oct_state_q)
      S_IDLE: begin
        oct_cnt_d = '0;
        if (oct_req) begin
          oct_step  = 1'b1;
          oct_dir_d = oct_up;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!oct_keep) oct_cnt_d = '0;
        else if (oct_cnt_q == ((oct_state_q == S_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
          oct_step  = 1'b1;
          oct_cnt_d = '0;
        end else oct_cnt_d = oct_cnt_q + CNT_W'(1);
      end
      default: oct_cnt_d = '0;
    endcase
    case (adsr_state_q)
      S_IDLE: begin
        adsr_cnt_d = '0;
        if (adsr_req) begin
          adsr_step  = 1'b1;
          adsr_dir_d = adsr_up;
          adsr_sel_d = ADSR_selector;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!adsr_keep) adsr_cnt_d = '0;
        else if (adsr_cnt_q == ((adsr_state_q == S_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
          adsr_step  = 1'b1;
          adsr_cnt_d = '0;
        end else adsr_cnt_d = adsr_cnt_q + CNT_W'(1);
      end
      default: adsr_cnt_d = '0;
    endcase
  end

  // Parameter bank update; only the addressed register moves
  always_comb begin
    octave_d = octave_q;
    amp_d    = amp_q;
    att_d    = att_q;
    dec_d    = dec_q;
    sus_d    = sus_q;
    rel_d    = rel_q;
    step_dir = adsr_dir_d;
    step_sel = adsr_sel_d;
    if (oct_step) begin
      if (oct_dir_d) octave_d = (octave_q >= OCT_TOP) ? OCT_TOP : octave_q + OW'(1);
      else           octave_d = (octave_q == '0) ? '0 : octave_q - OW'(1);
    end
    if (adsr_step) begin
      case (step_sel)
        3'd0:    amp_d = sat_step(amp_q, step_dir);
        3'd1:    att_d = sat_step(att_q, step_dir);
        3'd2:    dec_d = sat_step(dec_q, step_dir);
        3'd3:    sus_d = sat_step(sus_q, step_dir);
        3'd4:    rel_d = sat_step(rel_q, step_dir);
        default: ;
      endcase
    end
    param_changed_d = (octave_d != octave_q) || (amp_d != amp_q) || (att_d != att_q) ||
                      (dec_d != dec_q) || (sus_d != sus_q) || (rel_d != rel_q);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      oct_cnt_q       <= '0;
      oct_dir_q       <= 1'b0;
      adsr_cnt_q      <= '0;
      adsr_dir_q      <= 1'b0;
      adsr_sel_q      <= '0;
      octave_q        <= OCT_RESET;
      amp_q           <= PW'(MAX_W);
      att_q           <= PW'(MAX_W);
      dec_q           <= '0;
      sus_q           <= PW'(MAX_W);
      rel_q           <= PW'(MAX_W);
      param_changed_q <= 1'b0;
    end else begin
      oct_cnt_q       <= oct_cnt_d;
      oct_dir_q       <= oct_dir_d;
      adsr_cnt_q      <= adsr_cnt_d;
      adsr_dir_q      <= adsr_dir_d;
      adsr_sel_q      <= adsr_sel_d;
      octave_q        <= octave_d;
      amp_q           <= amp_d;
      att_q           <= att_d;
      dec_q           <= dec_d;
      sus_q           <= sus_d;
      rel_q           <= rel_d;
      param_changed_q <= param_changed_d;
    end
  end

  assign octave        = octave_q;
  assign amplitude     = amp_q;
  assign attack        = att_q;
  assign decay         = dec_q;
  assign sustain       = sus_q;
  assign rel           = rel_q;
  assign param_changed = param_changed_q;

endmodule
